// File: rtl/superscalar_pkg.sv
// Shared definitions for the 2-way superscalar core: opcodes, instruction
// field positions and instruction-class helpers used by the issue logic.
package superscalar_pkg;

  // Instruction field positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  // R-type
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_MUL  = 6'b000010;
  localparam logic [5:0] OP_AND  = 6'b000011;
  localparam logic [5:0] OP_OR   = 6'b000100;
  localparam logic [5:0] OP_XOR  = 6'b000101;
  localparam logic [5:0] OP_SLL  = 6'b000110;
  localparam logic [5:0] OP_SRL  = 6'b000111;
  // I-type
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SUBI = 6'b001001;
  localparam logic [5:0] OP_ANDI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001011;
  localparam logic [5:0] OP_XORI = 6'b001100;
  // Memory
  localparam logic [5:0] OP_LW   = 6'b010000;
  localparam logic [5:0] OP_SW   = 6'b010001;
  // Control
  localparam logic [5:0] OP_BEQ  = 6'b011000;
  localparam logic [5:0] OP_BNE  = 6'b011001;
  localparam logic [5:0] OP_BLT  = 6'b011010;
  localparam logic [5:0] OP_BGE  = 6'b011011;
  localparam logic [5:0] OP_J    = 6'b100000;
  localparam logic [5:0] OP_NOP  = 6'b111111;

  function automatic logic is_rtype(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL};
  endfunction

  function automatic logic is_itype(input logic [5:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE};
  endfunction

  function automatic logic is_jump(input logic [5:0] op);
    return op == OP_J;
  endfunction

  function automatic logic is_ctrl(input logic [5:0] op);
    return is_branch(op) || is_jump(op);
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic writes_reg(input logic [5:0] op);
    return is_rtype(op) || is_itype(op) || (op == OP_LW);
  endfunction

  // rs is a source for everything except J, NOP and undefined opcodes
  function automatic logic reads_rs(input logic [5:0] op);
    return is_rtype(op) || is_itype(op) || is_mem(op) || is_branch(op);
  endfunction

  // rt is a source only where it is not the destination
  function automatic logic reads_rt(input logic [5:0] op);
    return is_rtype(op) || (op == OP_SW) || is_branch(op);
  endfunction

  // Destination register index; 0 for instructions that write nothing
  function automatic logic [4:0] dest_reg(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[OP_HI:OP_LO];
    if (!writes_reg(op)) return 5'd0;
    if (is_rtype(op)) return ins[RD_HI:RD_LO];
    return ins[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/ssp_alu.sv
// Per-slot execute unit: ALU result, load/store address and branch outcome.
module ssp_alu
  import superscalar_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [15:0]     i_imm,
  output logic [XLEN-1:0] o_result,
  output logic            o_branch_taken
);

  logic [XLEN-1:0] w_sext;
  logic [XLEN-1:0] w_zext;

  assign w_sext = {{(XLEN-16){i_imm[15]}}, i_imm};
  assign w_zext = {{(XLEN-16){1'b0}}, i_imm};

  // Decode the opcode into a result value and a branch decision
  always_comb begin
    o_result       = '0;
    o_branch_taken = 1'b0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_MUL:  o_result = i_a * i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLL:  o_result = i_a << i_b[4:0];
      OP_SRL:  o_result = i_a >> i_b[4:0];
      OP_ADDI: o_result = i_a + w_sext;
      OP_SUBI: o_result = i_a - w_sext;
      OP_ANDI: o_result = i_a & w_zext;
      OP_ORI:  o_result = i_a | w_zext;
      OP_XORI: o_result = i_a ^ w_zext;
      OP_LW,
      OP_SW:   o_result = i_a + w_sext;
      OP_BEQ:  o_branch_taken = (i_a == i_b);
      OP_BNE:  o_branch_taken = (i_a != i_b);
      OP_BLT:  o_branch_taken = ($signed(i_a) <  $signed(i_b));
      OP_BGE:  o_branch_taken = ($signed(i_a) >= $signed(i_b));
      default: ;
    endcase
  end

endmodule

// File: rtl/superscalar_processor.sv
// In-order 2-way superscalar core. Fetches MEM[pc] and MEM[pc+1] each cycle,
// issues one or both, and commits all results on the same clk1 edge.
module superscalar_processor
  import superscalar_pkg::*;
#(
  parameter  int MEM_DEPTH = 1024,
  parameter  int XLEN      = 32,
  localparam int PW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk1,
  input  logic          reset,
  output logic [PW-1:0] pc,
  output logic [1:0]    issued
);

  // Architectural state; names are fixed so programs can be preloaded
  logic [XLEN-1:0] REG [0:31];
  logic [XLEN-1:0] MEM [0:MEM_DEPTH-1];

  logic [PW-1:0] r_pc;
  logic [1:0]    r_issued;

  // Per-slot signals (index 0 = older instruction at pc)
  logic [PW-1:0]   w_addr       [2];
  logic [XLEN-1:0] w_ins        [2];
  logic [5:0]      w_op         [2];
  logic [4:0]      w_rs         [2];
  logic [4:0]      w_rt         [2];
  logic [XLEN-1:0] w_rs_val     [2];
  logic [XLEN-1:0] w_rt_val     [2];
  logic [XLEN-1:0] w_alu_res    [2];
  logic            w_taken      [2];
  logic [4:0]      w_dest       [2];
  logic            w_wen        [2];
  logic [PW-1:0]   w_mem_addr   [2];
  logic [XLEN-1:0] w_wdata      [2];
  logic [PW-1:0]   w_target     [2];
  logic            w_redirect   [2];
  logic            w_issue      [2];

  logic          w_raw;
  logic          w_waw;
  logic          w_dual;
  logic [1:0]    w_count;
  logic [PW-1:0] w_next_pc;

  assign w_addr[0] = r_pc;
  assign w_addr[1] = r_pc + PW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign w_ins[gi]    = MEM[w_addr[gi]];
      assign w_op[gi]     = w_ins[gi][OP_HI:OP_LO];
      assign w_rs[gi]     = w_ins[gi][RS_HI:RS_LO];
      assign w_rt[gi]     = w_ins[gi][RT_HI:RT_LO];
      assign w_rs_val[gi] = REG[w_rs[gi]];
      assign w_rt_val[gi] = REG[w_rt[gi]];

      ssp_alu #(
        .XLEN (XLEN)
      ) u_alu (
        .i_op           (w_op[gi]),
        .i_a            (w_rs_val[gi]),
        .i_b            (w_rt_val[gi]),
        .i_imm          (w_ins[gi][IMM_HI:IMM_LO]),
        .o_result       (w_alu_res[gi]),
        .o_branch_taken (w_taken[gi])
      );

      // R0 is hardwired by never enabling a write to it
      assign w_dest[gi]     = dest_reg(w_ins[gi]);
      assign w_wen[gi]      = writes_reg(w_op[gi]) && (w_dest[gi] != 5'd0);
      assign w_mem_addr[gi] = w_alu_res[gi][PW-1:0];
      assign w_wdata[gi]    = (w_op[gi] == OP_LW) ? MEM[w_mem_addr[gi]] : w_alu_res[gi];

      // Targets are relative to the slot's own address and wrap with pc width
      assign w_target[gi] = w_addr[gi] + PW'(1) +
                            (is_jump(w_op[gi]) ? PW'(w_ins[gi][TGT_HI:TGT_LO])
                                               : PW'({{16{w_ins[gi][15]}}, w_ins[gi][IMM_HI:IMM_LO]}));
      assign w_redirect[gi] = is_jump(w_op[gi]) || (is_branch(w_op[gi]) && w_taken[gi]);
    end
  endgenerate

  // Slot1 reading a value slot0 is producing in the same cycle
  assign w_raw = w_wen[0] &&
                 ((reads_rs(w_op[1]) && (w_rs[1] == w_dest[0])) ||
                  (reads_rt(w_op[1]) && (w_rt[1] == w_dest[0])));
  assign w_waw = w_wen[0] && w_wen[1] && (w_dest[0] == w_dest[1]);

  assign w_dual     = !is_ctrl(w_op[0]) && !w_raw && !w_waw &&
                      !(is_mem(w_op[0]) && is_mem(w_op[1]));
  assign w_issue[0] = 1'b1;
  assign w_issue[1] = w_dual;
  assign w_count    = w_dual ? 2'd2 : 2'd1;

  // Redirect from the oldest issued taken control instruction, else advance
  always_comb begin
    w_next_pc = r_pc + PW'(w_count);
    if (w_redirect[0]) begin
      w_next_pc = w_target[0];
    end else if (w_issue[1] && w_redirect[1]) begin
      w_next_pc = w_target[1];
    end
  end

  // Fetch pointer and retire count
  always_ff @(posedge clk1) begin
    if (reset) begin
      r_pc     <= '0;
      r_issued <= 2'd0;
    end else begin
      r_pc     <= w_next_pc;
      r_issued <= w_count;
    end
  end

  // Commit register writes of both slots; storage is never cleared by reset
  always_ff @(posedge clk1) begin
    if (!reset) begin
      if (w_issue[0] && w_wen[0]) REG[w_dest[0]] <= w_wdata[0];
      if (w_issue[1] && w_wen[1]) REG[w_dest[1]] <= w_wdata[1];
    end
  end

  // Commit stores; at most one slot holds a memory op when both issue
  always_ff @(posedge clk1) begin
    if (!reset) begin
      if (w_issue[0] && (w_op[0] == OP_SW)) MEM[w_mem_addr[0]] <= w_rt_val[0];
      if (w_issue[1] && (w_op[1] == OP_SW)) MEM[w_mem_addr[1]] <= w_rt_val[1];
    end
  end

  assign pc     = r_pc;
  assign issued = r_issued;

endmodule

// File: tb/tb_superscalar_processor.sv
// Directed program for the 2-way core: dual issue, jump in slot1, RAW split,
// load/store, branches, immediates, shifts and a mid-program reset.
module tb_superscalar_processor;

  localparam int PW = 10;

  localparam logic [5:0] T_ADD  = 6'b000000;
  localparam logic [5:0] T_SUB  = 6'b000001;
  localparam logic [5:0] T_MUL  = 6'b000010;
  localparam logic [5:0] T_SLL  = 6'b000110;
  localparam logic [5:0] T_SRL  = 6'b000111;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ORI  = 6'b001011;
  localparam logic [5:0] T_LW   = 6'b010000;
  localparam logic [5:0] T_SW   = 6'b010001;
  localparam logic [5:0] T_BEQ  = 6'b011000;
  localparam logic [5:0] T_BNE  = 6'b011001;
  localparam logic [5:0] T_BLT  = 6'b011010;
  localparam logic [5:0] T_J    = 6'b100000;
  localparam logic [31:0] T_NOP = 32'hFC00_0000;

  logic          clk1  = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] pc;
  logic [1:0]    issued;

  int n_checks = 0;
  int n_errors = 0;

  superscalar_processor #(
    .MEM_DEPTH (1024),
    .XLEN      (32)
  ) dut (
    .clk1   (clk1),
    .reset  (reset),
    .pc     (pc),
    .issued (issued)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input int t);
    return {T_J, 26'(t)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input int exp_pc, input int exp_iss);
    @(posedge clk1);
    #1;
    $display("edge %s: reset=%0b pc=%0d issued=%0d", tag, reset, pc, issued);
    check({tag, ".pc"}, 32'(pc), 32'(exp_pc));
    check({tag, ".issued"}, 32'(issued), 32'(exp_iss));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dut.REG[i] = 32'(i);
    dut.REG[31] = 32'hFFFF_FFFF;
    for (int i = 0; i < 1024; i++) dut.MEM[i] = T_NOP;

    dut.MEM[0]  = enc_r(T_ADD, 1, 2, 14);
    dut.MEM[1]  = enc_r(T_ADD, 2, 4, 15);
    dut.MEM[2]  = enc_r(T_ADD, 1, 5, 17);
    dut.MEM[3]  = enc_j(10);                       // 3+1+10 = 14
    dut.MEM[8]  = enc_i(T_BEQ, 1, 1, 16'd3);       // 8+1+3 = 12
    dut.MEM[12] = enc_i(T_BLT, 31, 1, 16'd17);     // 12+1+17 = 30
    dut.MEM[14] = enc_r(T_ADD, 1, 4, 18);
    dut.MEM[15] = enc_r(T_ADD, 1, 7, 19);
    dut.MEM[16] = enc_r(T_ADD, 1, 8, 20);
    dut.MEM[17] = enc_r(T_ADD, 1, 9, 21);
    dut.MEM[18] = enc_i(T_ADDI, 3, 3, 16'd5);
    dut.MEM[19] = enc_r(T_ADD, 3, 1, 4);
    dut.MEM[20] = enc_i(T_SW, 4, 5, 16'd91);       // MEM[9+91] <= R5
    dut.MEM[21] = enc_i(T_LW, 0, 6, 16'd100);
    dut.MEM[22] = enc_r(T_ADD, 6, 0, 23);
    dut.MEM[23] = enc_j(1008);                     // 23+1+1008 wraps to 8
    dut.MEM[30] = enc_i(T_BNE, 2, 2, 16'd5);
    dut.MEM[31] = enc_i(T_ADDI, 0, 24, 16'hFFFE);
    dut.MEM[32] = enc_i(T_ORI, 0, 25, 16'h8001);
    dut.MEM[33] = enc_r(T_SUB, 9, 10, 26);
    dut.MEM[34] = enc_r(T_MUL, 7, 8, 27);
    dut.MEM[35] = enc_r(T_SLL, 1, 7, 28);
    dut.MEM[36] = enc_r(T_SRL, 31, 8, 29);

    reset = 1'b1;
    step("rst0", 0, 0);
    step("rst1", 0, 0);
    check("rst.R14", dut.REG[14], 32'd14);
    check("rst.R31", dut.REG[31], 32'hFFFF_FFFF);
    reset = 1'b0;

    step("dual_add", 2, 2);
    check("R14", dut.REG[14], 32'd3);
    check("R15", dut.REG[15], 32'd6);

    step("jump_slot1", 14, 2);
    check("R17", dut.REG[17], 32'd6);

    step("after_j_a", 16, 2);
    check("R18", dut.REG[18], 32'd5);
    check("R19", dut.REG[19], 32'd8);
    step("after_j_b", 18, 2);
    check("R20", dut.REG[20], 32'd9);
    check("R21", dut.REG[21], 32'd10);

    step("raw_a", 19, 1);
    check("R3", dut.REG[3], 32'd8);
    check("R4_before", dut.REG[4], 32'd4);
    step("raw_b", 20, 1);
    check("R4", dut.REG[4], 32'd9);

    step("sw", 21, 1);
    check("MEM100", dut.MEM[100], 32'd5);
    check("R6_before", dut.REG[6], 32'd6);
    step("lw", 22, 1);
    check("R6", dut.REG[6], 32'd5);

    step("wrap_jump", 8, 2);
    check("R23", dut.REG[23], 32'd5);

    step("beq", 12, 1);
    step("blt_neg", 30, 1);
    step("bne_nt", 31, 1);

    step("imm", 33, 2);
    check("R24_sext", dut.REG[24], 32'hFFFF_FFFE);
    check("R25_zext", dut.REG[25], 32'h0000_8001);

    step("sub_mul", 35, 2);
    check("R26", dut.REG[26], 32'hFFFF_FFFF);
    check("R27", dut.REG[27], 32'd56);

    step("shifts", 37, 2);
    check("R28", dut.REG[28], 32'd128);
    check("R29", dut.REG[29], 32'h00FF_FFFF);

    reset = 1'b1;
    step("mid_reset", 0, 0);
    check("keep.R29", dut.REG[29], 32'h00FF_FFFF);
    check("keep.MEM100", dut.MEM[100], 32'd5);
    reset = 1'b0;

    step("restart", 2, 2);
    check("R14_again", dut.REG[14], 32'd3);
    check("R15_again", dut.REG[15], 32'd11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/superscalar_processor.md
Name: superscalar_processor

Overview:
- In-order, 2-way superscalar 32-bit processor core with a unified word-addressed memory and a 32-entry register file.
- Each cycle it fetches the instruction pair at PC and PC+1 and issues one or both.
- Issued instructions execute and retire in that same cycle.
- Top-level CPU block: no bus interface. Program and data are preloaded hierarchically into the arrays REG and MEM, which must keep exactly these names.

Parameters:
- MEM_DEPTH, 1024: words in MEM. PC width is clog2(MEM_DEPTH).
- XLEN, 32: data and instruction width.

Ports:
- clk1  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high.
- pc  output  clog2(MEM_DEPTH)  current fetch address (debug).
- issued  output  2  instructions retired on the last edge: 0, 1 or 2 (debug).

Behaviour:
- Storage:
  - REG[0:31] x32.
  - MEM[0:MEM_DEPTH-1] x32, combinational read, write on clk1.
  - R0 writes are ignored.
- Reset:
  - On clk1 with reset=1: pc<=0, issued<=0.
  - REG and MEM are NOT cleared, so preloaded contents survive reset.
- Encoding:
  - op[31:26], rs[25:21], rt[20:16], rd[15:11], imm16[15:0], target26[25:0].
- Opcodes:
  - R-type, rd <= f(rs,rt): ADD 000000, SUB 000001, MUL 000010 (low 32 bits), AND 000011, OR 000100, XOR 000101, SLL 000110, SRL 000111 (shift amount rt[4:0], logical).
  - I-type, rt <= f(rs,imm):
    - ADDI 001000, SUBI 001001: imm sign-extended.
    - ANDI 001010, ORI 001011, XORI 001100: imm zero-extended.
  - LW 010000: rt <= MEM[rs+sext(imm)].
  - SW 010001: MEM[rs+sext(imm)] <= rt.
  - Addresses wrap modulo MEM_DEPTH.
  - Branches compare rs with rt: BEQ 011000, BNE 011001, BLT 011010 (signed), BGE 011011 (signed). Taken target = A+1+sext(imm16), where A is the branch's own address.
  - J 100000: target = A+1+target26, modulo MEM_DEPTH.
  - NOP 111111; any undefined opcode executes as NOP.
- Issue rule:
  - slot0 = MEM[pc], slot1 = MEM[pc+1].
  - Only slot0 issues (single-issue) when any of these holds:
    - slot0 is a branch or J;
    - slot1 reads slot0's destination (RAW);
    - both slots write the same non-zero register;
    - both are LW/SW.
  - Otherwise both issue.
- Retire:
  - All operands are read from REG before the edge.
  - Register and memory writes of both slots commit on the same clk1 edge.
- Next PC:
  - Taken branch or J in an issued slot at address A: its target.
  - Otherwise pc + issued count.
  - pc+1 and all targets wrap modulo MEM_DEPTH.
- Control instruction in slot1 alongside an independent slot0: both retire in the same cycle.
- Execution never halts: NOP regions are walked and pc wraps.

Decomposition:
- Package superscalar_pkg holds:
  - opcode localparams;
  - field-slice positions;
  - instruction-class helper functions (is_branch, is_mem, writes_reg, dest_reg).
- One natural sub-module: ssp_alu. It is purely combinational (op, a, b, imm -> result, branch_taken) and is instantiated twice, once per slot.

Test Plan:
- Preload REG[i]=i. Hold reset for two edges. Expected: pc=0, REG unchanged.
- Dual-issue ALU: MEM[0]=ADD R1,R2->R14, MEM[1]=ADD R2,R4->R15. After the first edge: R14=3, R15=6, pc=2, issued=2.
- Jump in slot1: MEM[2]=ADD R1,R5->R17, MEM[3]=J 10. Expected: R17=6, next pc=14. Then MEM[14..17] (ADD R1 with R4/R7/R8/R9 -> R18..R21) give R18=5, R19=8, R20=9, R21=10, two instructions per cycle.
- RAW split: ADDI R3,R3,5 -> R3 followed by ADD R3,R1->R4. Expected: issued=1 then 1, R3=8, R4=9.
- Load/store: SW R5 -> MEM[R0+100], then LW from MEM[100] -> R6. Expected: single-issue per memory op, MEM[100]=5, R6=5.
- Branches:
  - BEQ R1,R1,+3 at address 8: next pc=12.
  - BLT on R31 with value -1 vs R1: taken.
  - BNE with equal operands: not taken, pc advances by issued count.
  - Reset asserted mid-program: pc=0 on the next edge, REG retained.
